// File: rtl/memref_arb_pkg.sv
// Shared types and default constants for the memref read-port arbiter.
package memref_arb_pkg;

  typedef enum logic [0:0] {
    ST_ARB    = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  localparam int DEF_N_REQ      = 4;
  localparam int DEF_ADDR_W     = 6;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_RD_LATENCY = 1;
  localparam int DEF_LOCK_MAX   = 16;

endpackage

// File: rtl/memref_rd_arbiter_rr_pick.sv
// Round-robin picker: lowest requesting index at or after i_start (wrapping) wins.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_start,
  output logic [N-1:0]     o_grant
);

  always_comb begin : p_pick
    logic w_found;
    int   j;
    o_grant = '0;
    w_found = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = int'(i_start) + k;
      if (j >= N) j = j - N;
      if (!w_found && i_req[j]) begin
        o_grant[j] = 1'b1;
        w_found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/memref_rd_arbiter.sv
// N-way arbiter onto one memref read port with lock support and an in-order tag pipeline.
module memref_rd_arbiter
  import memref_arb_pkg::*;
#(
  parameter int N_REQ      = DEF_N_REQ,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int RD_LATENCY = DEF_RD_LATENCY,
  parameter int LOCK_MAX   = DEF_LOCK_MAX
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ-1:0]        req_lock,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  output logic [N_REQ-1:0]        req_ready,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]       rsp_data,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic                    mem_rd_en,
  input  logic [DATA_W-1:0]       mem_rd_data,
  output logic                    lock_abort,
  output logic [0:0]              o_dbg_state
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(LOCK_MAX + 1);
  localparam int PIPE  = RD_LATENCY + 1;

  arb_state_e        r_state;
  logic [IDX_W-1:0]  r_last_grant;
  logic [IDX_W-1:0]  r_owner;
  logic [CNT_W-1:0]  r_idle_cnt;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_rd_en;
  logic [PIPE-1:0]   r_pv;
  logic [IDX_W-1:0]  r_pi [PIPE];

  logic [IDX_W-1:0]  w_start;
  logic              w_abort;
  logic [N_REQ-1:0]  w_owner_oh;
  logic [N_REQ-1:0]  w_req_mask;
  logic [N_REQ-1:0]  w_grant;
  logic              w_accept;
  logic [IDX_W-1:0]  w_acc_idx;
  logic              w_acc_lock;
  logic [ADDR_W-1:0] w_acc_addr;

  assign w_start    = (r_last_grant == IDX_W'(N_REQ - 1)) ? '0 : r_last_grant + 1'b1;
  assign w_abort    = (r_state == ST_LOCKED) && (r_idle_cnt == CNT_W'(LOCK_MAX));
  assign w_owner_oh = {{(N_REQ-1){1'b0}}, 1'b1} << r_owner;

  // Handshake: a beat for requester i transfers in a cycle where req_valid[i] && req_ready[i];
  // req_ready is one-hot-or-zero and never depends on req_ready itself.
  always_comb begin
    w_req_mask = '0;
    if (rst_n && !w_abort) begin
      if (r_state == ST_ARB) w_req_mask = req_valid;
      else                   w_req_mask = req_valid & w_owner_oh;
    end
  end

  rr_pick #(.N(N_REQ), .IDX_W(IDX_W)) u_rr_pick (
    .i_req   (w_req_mask),
    .i_start (w_start),
    .o_grant (w_grant)
  );

  assign req_ready = w_grant;
  assign w_accept  = |w_grant;

  always_comb begin
    w_acc_idx  = '0;
    w_acc_lock = 1'b0;
    w_acc_addr = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant[i]) begin
        w_acc_idx  = IDX_W'(i);
        w_acc_lock = req_lock[i];
        w_acc_addr = req_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_ARB;
      r_last_grant <= IDX_W'(N_REQ - 1);
      r_owner      <= '0;
      r_idle_cnt   <= '0;
      r_mem_addr   <= '0;
      r_mem_rd_en  <= 1'b0;
    end else begin
      r_mem_rd_en <= w_accept;
      if (w_accept) begin
        r_mem_addr   <= w_acc_addr;
        r_last_grant <= w_acc_idx;
      end
      case (r_state)
        ST_ARB: begin
          if (w_accept && w_acc_lock) begin
            r_state    <= ST_LOCKED;
            r_owner    <= w_acc_idx;
            r_idle_cnt <= '0;
          end
        end
        ST_LOCKED: begin
          // Abort masks all grants this cycle, so last_grant is written only here.
          if (w_abort) begin
            r_state      <= ST_ARB;
            r_last_grant <= r_owner;
            r_idle_cnt   <= '0;
          end else if (w_accept) begin
            r_idle_cnt <= '0;
            if (!w_acc_lock) r_state <= ST_ARB;
          end else begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
          end
        end
        default: r_state <= ST_ARB;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pv <= '0;
    end else begin
      r_pv[0] <= w_accept;
      for (int k = 1; k < PIPE; k++) r_pv[k] <= r_pv[k-1];
    end
  end

  always_ff @(posedge clk) begin
    r_pi[0] <= w_acc_idx;
    for (int k = 1; k < PIPE; k++) r_pi[k] <= r_pi[k-1];
  end

  always_comb begin
    rsp_valid = '0;
    if (r_pv[PIPE-1]) rsp_valid[r_pi[PIPE-1]] = 1'b1;
  end

  assign rsp_data    = mem_rd_data;
  assign mem_addr    = r_mem_addr;
  assign mem_rd_en   = r_mem_rd_en;
  assign lock_abort  = w_abort;
  assign o_dbg_state = r_state;

endmodule

// File: doc/memref_rd_arbiter.md
MEMREF_RD_ARBITER -- requirements
Module: memref_rd_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of requesters sharing one memref read port.
REQ-002 SHALL have parameter ADDR_W, default 6: memref address width.
REQ-003 SHALL have parameter DATA_W, default 32: read data width.
REQ-004 SHALL have parameter RD_LATENCY, default 1: cycles from mem_rd_en to valid mem_rd_data; legal range 0..3.
REQ-005 SHALL have parameter LOCK_MAX, default 16: maximum cycles a lock may be held without an accepted beat.
REQ-006 clk  in  1  single clock; all state updates on rising edge.
REQ-007 rst_n  in  1  synchronous, active-low reset.
REQ-008 req_valid  in  N_REQ  per-requester read request.
REQ-009 req_lock  in  N_REQ  requester asks to keep ownership after this beat.
REQ-010 req_addr  in  N_REQ*ADDR_W  packed addresses; requester i at slice i.
REQ-011 req_ready  out  N_REQ  one-hot-or-zero accept.
REQ-012 rsp_valid  out  N_REQ  one-hot-or-zero: read data for requester i is present.
REQ-013 rsp_data  out  DATA_W  shared response data, qualified by rsp_valid.
REQ-014 mem_addr  out  ADDR_W  registered address to the memref.
REQ-015 mem_rd_en  out  1  registered read strobe.
REQ-016 mem_rd_data  in  DATA_W  memref read data.
REQ-017 lock_abort  out  1  one-cycle pulse when a lock is forcibly released.

Function
REQ-018 A beat SHALL be accepted for requester i in cycle t iff req_valid[i] and req_ready[i]; req_ready SHALL be combinational from req_valid, state and pointer.
REQ-019 At most one beat SHALL be accepted per cycle; the accepted address SHALL appear on mem_addr with mem_rd_en=1 in cycle t+1.
REQ-020 If no beat is accepted in cycle t, mem_rd_en SHALL be 0 in t+1 and mem_addr SHALL hold its previous value.
REQ-021 rsp_valid[i] SHALL be 1 in cycle t+1+RD_LATENCY, with rsp_data = mem_rd_data in that cycle; the requester tag travels in a (1+RD_LATENCY)-deep valid/index pipeline.
REQ-022 Back-to-back beats SHALL be accepted every cycle with no bubble; responses return in acceptance order.
REQ-023 State ARB: round-robin arbitration; the search starts at last_grant+1 modulo N_REQ, and the lowest index at or after that point wins.
REQ-024 last_grant SHALL update only on an accepted beat.
REQ-025 ARB->LOCKED on an accepted beat with req_lock[i]=1; owner := i.
REQ-026 In LOCKED, only owner may be granted, and req_ready of all other requesters SHALL be 0.
REQ-027 LOCKED->ARB on an owner beat accepted with req_lock=0; that beat is served normally.
REQ-028 In LOCKED, an idle counter SHALL count cycles without an owner beat, clearing on each owner beat.
REQ-029 When the idle counter reaches LOCK_MAX: transition to ARB, pulse lock_abort for one cycle, and set last_grant := owner.
REQ-030 When an abort and an owner request coincide in the same cycle, the abort SHALL win: the owner is not granted that cycle.
REQ-031 An in-flight response SHALL never be dropped or blocked by lock or abort events.
REQ-032 Pointer wrap: with last_grant = N_REQ-1, the search starts at 0.

Reset
REQ-033 While rst_n=0 at a clock edge: state := ARB, last_grant := N_REQ-1 (so requester 0 has first priority), idle counter := 0, tag pipeline cleared.
REQ-034 Output values after a reset edge: mem_rd_en=0, mem_addr=0, rsp_valid=0, rsp_data=don't-care, lock_abort=0.
REQ-035 req_ready SHALL be 0 in any cycle where rst_n=0.
REQ-036 A reset asserted mid-operation SHALL discard all in-flight responses; no rsp_valid SHALL appear for beats accepted before the reset edge.

Structure
REQ-037 Package memref_arb_pkg SHALL hold the state enum (ARB, LOCKED) and the default parameter constants.
REQ-038 A combinational sub-module rr_pick SHALL hold the round-robin picker (inputs: request vector, start index; output: one-hot grant).

Verification (RD_LATENCY=1, N_REQ=4)
REQ-039 All four req_valid held high for 8 cycles after reset -> grants in order 0,1,2,3,0,1,2,3, one per cycle; rsp_valid follows each grant 2 cycles later with the matching data.
REQ-040 Requester 2 alone, addresses 5,6,7 on consecutive cycles -> mem_addr = 5,6,7 in cycles t+1..t+3; rsp_valid[2] in cycles t+2..t+4.
REQ-041 Requester 1 locks for 3 beats while 0 and 3 request -> no grants to 0 or 3 until the unlocking beat; the next grant goes to 3 (after 1 in round-robin order), not 0.
REQ-042 Requester 1 locks, then drops req_valid -> exactly LOCK_MAX=16 idle cycles later, lock_abort pulses for 1 cycle and requester 3 is granted on the following cycle.
REQ-043 rst_n pulsed low for one cycle while 2 beats are in flight -> no rsp_valid afterwards; the first post-reset grant goes to requester 0.
REQ-044 Rerun REQ-039 with RD_LATENCY=0 and RD_LATENCY=3 -> response latency of 1 and 4 cycles respectively, with order preserved.
